// File: rtl/pokey_audio_mixer_if.sv
// PCM sample stream between the POKEY mixer and its downstream consumer.
// Valid/ready handshake: a transfer happens on a rising clock edge where both are high.
interface pokey_audio_mixer_if;
    logic [5:0] sample;
    logic       sampleValid;
    logic       sampleReady;

    modport master (
        output sample,
        output sampleValid,
        input  sampleReady
    );

    modport slave (
        input  sample,
        input  sampleValid,
        output sampleReady
    );
endinterface

// File: rtl/pokey_audio_mixer.sv
// Mixes the four POKEY channels into a 6-bit level. The level drives a first-order
// sigma-delta DAC and a decimated PCM stream with valid/ready and a sticky overrun flag.
module pokey_audio_mixer #(
    parameter int SAMPLE_DIV  = 40,
    parameter int SYNC_STAGES = 2
) (
    input  logic        clk179,
    input  logic        init_L,
    input  logic        audio1,
    input  logic        audio2,
    input  logic        audio3,
    input  logic        audio4,
    input  logic [3:0]  vol1,
    input  logic [3:0]  vol2,
    input  logic [3:0]  vol3,
    input  logic [3:0]  vol4,
    input  logic [3:0]  volOnly,
    input  logic        mute,
    output logic        dacOut,
    output logic        overrun,
    input  logic        overrunClr,
    pokey_audio_mixer_if.master pcm
);

    localparam logic [15:0] DIV_LAST = 16'(SAMPLE_DIV - 1);

    logic [3:0]       w_audio;
    logic [3:0]       w_audio_s;
    logic [3:0][3:0]  w_vol;
    logic [3:0][3:0]  w_lvl;
    logic [5:0]       w_mix_next;
    logic [6:0]       w_acc_next;
    logic             w_strb;
    logic             w_xfer;
    logic             w_ovr_set;

    logic [5:0]       r_mix;
    logic [6:0]       r_acc;
    logic [15:0]      r_div;
    logic [5:0]       r_sample;
    logic             r_valid;
    logic             r_overrun;

    assign w_audio = {audio4, audio3, audio2, audio1};
    assign w_vol   = {vol4, vol3, vol2, vol1};

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_chan
            logic [SYNC_STAGES-1:0] r_sync;

            always_ff @(posedge clk179 or negedge init_L) begin
                if (!init_L) begin
                    r_sync <= '0;
                end else begin
                    r_sync <= {r_sync[SYNC_STAGES-2:0], w_audio[gi]};
                end
            end

            assign w_audio_s[gi] = r_sync[SYNC_STAGES-1];
            // Volume-only mode bypasses the waveform and outputs a DC level.
            assign w_lvl[gi] = (volOnly[gi] || w_audio_s[gi]) ? w_vol[gi] : 4'd0;
        end
    endgenerate

    assign w_mix_next = mute ? 6'd0
                      : 6'(w_lvl[0]) + 6'(w_lvl[1]) + 6'(w_lvl[2]) + 6'(w_lvl[3]);

    // Bit 6 of the accumulator is the carry out, so it is the DAC bit itself.
    assign w_acc_next = {1'b0, r_acc[5:0]} + {1'b0, r_mix};

    assign w_strb    = (r_div == DIV_LAST);
    assign w_xfer    = r_valid && pcm.sampleReady;
    assign w_ovr_set = w_strb && r_valid && !w_xfer;

    always_ff @(posedge clk179 or negedge init_L) begin
        if (!init_L) begin
            r_mix <= '0;
            r_acc <= '0;
            r_div <= '0;
        end else begin
            r_mix <= w_mix_next;
            r_acc <= w_acc_next;
            r_div <= w_strb ? 16'd0 : r_div + 16'd1;
        end
    end

    always_ff @(posedge clk179 or negedge init_L) begin
        if (!init_L) begin
            r_sample <= '0;
            r_valid  <= 1'b0;
        end else if (w_strb && (!r_valid || w_xfer)) begin
            r_sample <= r_mix;
            r_valid  <= 1'b1;
        end else if (w_xfer) begin
            r_valid  <= 1'b0;
        end
    end

    // A new overrun event takes priority over a simultaneous clear.
    always_ff @(posedge clk179 or negedge init_L) begin
        if (!init_L) begin
            r_overrun <= 1'b0;
        end else if (w_ovr_set) begin
            r_overrun <= 1'b1;
        end else if (overrunClr) begin
            r_overrun <= 1'b0;
        end
    end

    assign dacOut          = r_acc[6];
    assign overrun         = r_overrun;
    assign pcm.sample      = r_sample;
    assign pcm.sampleValid = r_valid;

endmodule

// File: tb/tb_pokey_audio_mixer.sv
// Directed bench for pokey_audio_mixer: a vector table of channel setups plus
// hand-written sequences for reset, sync latency, handshake and overrun corners.
module tb_pokey_audio_mixer;

    logic       clk179 = 1'b0;
    logic       init_L = 1'b0;
    logic       audio1 = 1'b0, audio2 = 1'b0, audio3 = 1'b0, audio4 = 1'b0;
    logic [3:0] vol1 = '0, vol2 = '0, vol3 = '0, vol4 = '0;
    logic [3:0] volOnly = '0;
    logic       mute = 1'b0;
    logic       overrunClr = 1'b0;
    logic       dacOut;
    logic       overrun;

    pokey_audio_mixer_if pcm_if ();

    pokey_audio_mixer #(.SAMPLE_DIV(40), .SYNC_STAGES(2)) dut (
        .clk179     (clk179),
        .init_L     (init_L),
        .audio1     (audio1),
        .audio2     (audio2),
        .audio3     (audio3),
        .audio4     (audio4),
        .vol1       (vol1),
        .vol2       (vol2),
        .vol3       (vol3),
        .vol4       (vol4),
        .volOnly    (volOnly),
        .mute       (mute),
        .dacOut     (dacOut),
        .overrun    (overrun),
        .overrunClr (overrunClr),
        .pcm        (pcm_if.master)
    );

    always #5 clk179 = ~clk179;

    typedef struct {
        logic [3:0] vo;
        logic [3:0] v1, v2, v3, v4;
        logic [3:0] au;
        logic       m;
        int         exp_mix;
    } vec_t;

    vec_t vecs[8];
    int   total = 0;
    int   bad   = 0;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end else begin
            $display("ok   %s: %0d", name, act);
        end
    endtask

    // Inputs change and outputs are sampled on the falling edge.
    task automatic step(input int n);
        repeat (n) @(negedge clk179);
    endtask

    task automatic set_ch(input logic [3:0] vo, input logic [3:0] v1, input logic [3:0] v2,
                          input logic [3:0] v3, input logic [3:0] v4, input logic [3:0] au,
                          input logic m);
        volOnly = vo;
        vol1 = v1; vol2 = v2; vol3 = v3; vol4 = v4;
        {audio4, audio3, audio2, audio1} = au;
        mute = m;
    endtask

    task automatic count_ones(output int ones);
        ones = 0;
        for (int i = 0; i < 64; i++) begin
            step(1);
            ones += int'(dacOut);
        end
    endtask

    task automatic wait_valid(input int budget, input string name);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            if (pcm_if.sampleValid) begin
                ok = 1'b1;
                break;
            end
            step(1);
        end
        if (!ok) chk({name, "_timeout"}, 0, 1);
    endtask

    initial begin
        int ones;
        pcm_if.sampleReady = 1'b0;

        vecs[0] = '{4'b1111, 4'd15, 4'd15, 4'd15, 4'd15, 4'b0000, 1'b0, 60};
        vecs[1] = '{4'b0000, 4'd8,  4'd0,  4'd0,  4'd0,  4'b0001, 1'b0, 8};
        vecs[2] = '{4'b0000, 4'd1,  4'd2,  4'd4,  4'd8,  4'b1111, 1'b0, 15};
        vecs[3] = '{4'b0101, 4'd3,  4'd5,  4'd7,  4'd9,  4'b0000, 1'b0, 10};
        vecs[4] = '{4'b0000, 4'd3,  4'd5,  4'd7,  4'd9,  4'b1010, 1'b0, 14};
        vecs[5] = '{4'b1111, 4'd15, 4'd15, 4'd15, 4'd15, 4'b0000, 1'b1, 0};
        vecs[6] = '{4'b0000, 4'd8,  4'd0,  4'd0,  4'd0,  4'b0000, 1'b0, 0};
        vecs[7] = '{4'b0011, 4'd15, 4'd15, 4'd0,  4'd0,  4'b1100, 1'b0, 30};

        // Reset state and first strobe timing
        step(2);
        chk("rst_dac", int'(dacOut), 0);
        chk("rst_sample", int'(pcm_if.sample), 0);
        chk("rst_valid", int'(pcm_if.sampleValid), 0);
        chk("rst_overrun", int'(overrun), 0);
        init_L = 1'b1;
        step(39);
        chk("first_strb_pre_valid", int'(pcm_if.sampleValid), 0);
        step(1);
        chk("first_strb_valid", int'(pcm_if.sampleValid), 1);
        chk("first_strb_sample", int'(pcm_if.sample), 0);
        #2 init_L = 1'b0;
        #1 chk("async_rst_valid", int'(pcm_if.sampleValid), 0);
        step(1);
        init_L = 1'b1;

        // Vector table with the consumer always ready
        pcm_if.sampleReady = 1'b1;
        for (int v = 0; v < 8; v++) begin
            set_ch(vecs[v].vo, vecs[v].v1, vecs[v].v2, vecs[v].v3, vecs[v].v4,
                   vecs[v].au, vecs[v].m);
            step(5);
            chk($sformatf("vec%0d_mix", v), int'(dut.r_mix), vecs[v].exp_mix);
            count_ones(ones);
            chk($sformatf("vec%0d_ones64", v), ones, vecs[v].exp_mix);
            wait_valid(100, $sformatf("vec%0d_sample", v));
            chk($sformatf("vec%0d_sample", v), int'(pcm_if.sample), vecs[v].exp_mix);
        end

        // audio1 edge latency through the synchronizer, then volume latency
        set_ch(4'b0000, 4'd8, 4'd0, 4'd0, 4'd0, 4'b0000, 1'b0);
        step(5);
        chk("lat_mix_idle", int'(dut.r_mix), 0);
        audio1 = 1'b1;
        step(2);
        chk("lat_mix_t2", int'(dut.r_mix), 0);
        step(1);
        chk("lat_mix_t3", int'(dut.r_mix), 8);
        vol1 = 4'd4;
        step(1);
        chk("vol_lat_mix", int'(dut.r_mix), 4);
        audio1 = 1'b0;
        step(5);
        chk("low_dac", int'(dacOut), 0);
        count_ones(ones);
        chk("low_ones64", ones, 0);
        wait_valid(100, "low_sample");
        chk("low_sample", int'(pcm_if.sample), 0);

        // Overrun and handshake corners, aligned to a fresh reset
        pcm_if.sampleReady = 1'b0;
        set_ch(4'b1111, 4'd15, 4'd15, 4'd15, 4'd15, 4'b0000, 1'b0);
        init_L = 1'b0;
        step(1);
        init_L = 1'b1;
        step(40);
        chk("ovr_s1_valid", int'(pcm_if.sampleValid), 1);
        chk("ovr_s1_sample", int'(pcm_if.sample), 60);
        chk("ovr_s1_overrun", int'(overrun), 0);
        set_ch(4'b1111, 4'd5, 4'd5, 4'd5, 4'd5, 4'b0000, 1'b0);
        step(39);
        chk("ovr_pre_s2_overrun", int'(overrun), 0);
        step(1);
        chk("ovr_s2_overrun", int'(overrun), 1);
        chk("ovr_s2_sample", int'(pcm_if.sample), 60);
        chk("ovr_s2_valid", int'(pcm_if.sampleValid), 1);
        step(40);
        chk("ovr_s3_sample", int'(pcm_if.sample), 60);
        chk("ovr_s3_overrun", int'(overrun), 1);
        overrunClr = 1'b1;
        step(1);
        overrunClr = 1'b0;
        chk("ovr_clr", int'(overrun), 0);
        step(38);
        pcm_if.sampleReady = 1'b1;
        step(1);
        pcm_if.sampleReady = 1'b0;
        chk("xfer_strb_sample", int'(pcm_if.sample), 20);
        chk("xfer_strb_valid", int'(pcm_if.sampleValid), 1);
        chk("xfer_strb_overrun", int'(overrun), 0);
        step(39);
        overrunClr = 1'b1;
        step(1);
        overrunClr = 1'b0;
        chk("set_beats_clr_overrun", int'(overrun), 1);
        chk("set_beats_clr_sample", int'(pcm_if.sample), 20);
        step(1);
        chk("overrun_sticky", int'(overrun), 1);

        // Mute with all channels loud
        set_ch(4'b1111, 4'd15, 4'd15, 4'd15, 4'd15, 4'b0000, 1'b0);
        step(3);
        chk("mute_pre_mix", int'(dut.r_mix), 60);
        mute = 1'b1;
        step(1);
        chk("mute_mix", int'(dut.r_mix), 0);
        step(1);
        chk("mute_dac", int'(dacOut), 0);
        count_ones(ones);
        chk("mute_ones64", ones, 0);
        pcm_if.sampleReady = 1'b1;
        step(1);
        wait_valid(100, "mute_sample");
        chk("mute_sample", int'(pcm_if.sample), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pokey_audio_mixer.md
Name: pokey_audio_mixer

Overview:
Consumes the four POKEY channel outputs (audio1-4) and their 4-bit volumes from the audio generator, and mixes them into one 6-bit level. It produces a 1-bit first-order sigma-delta DAC stream for the board audio pin. It also emits a decimated 6-bit PCM sample stream, with a valid/ready handshake, for a downstream serializer or capture block. It sits between the POKEY audio generator and the board audio output.

Parameters:
SAMPLE_DIV, 40, clk179 cycles per PCM sample (about 44.7 kHz); legal range 2..65535.
SYNC_STAGES, 2, synchronizer depth for each audioN input; legal range 2..4.

Ports:
clk179  in  1  system clock (1.79 MHz); all state is clocked on its rising edge.
init_L  in  1  asynchronous, active-low reset.
audio1, audio2, audio3, audio4  in  1 each  channel waveform bits; asynchronous to clk179 (derived clocks).
vol1, vol2, vol3, vol4  in  4 each  channel volume (AUDCn[3:0]); quasi-static.
volOnly  in  4  bit n-1 = AUDCn[4]; when set, channel n outputs its volume level regardless of its waveform.
mute  in  1  forces the mix to 0.
dacOut  out  1  sigma-delta bitstream.
sample  out  6  PCM sample, 0..60.
sampleValid  out  1  sample holds valid data.
sampleReady  in  1  consumer accepts the sample.
overrun  out  1  sticky flag: a sample was dropped.
overrunClr  in  1  clears overrun.

Behaviour:
- Reset (init_L=0, asynchronous): all synchronizer flops, mix, accumulator, divider counter, sample and overrun go to 0; dacOut=0; sampleValid=0. Reset may assert mid-handshake; a pending sample is discarded.
- Sync: each audioN passes through SYNC_STAGES flops, giving audioN_s.
- Channel level: lvlN = volOnly[N-1] ? volN : (audioN_s ? volN : 0).
- Mix register: mix <= mute ? 0 : lvl1+lvl2+lvl3+lvl4.
  - Unsigned 6-bit sum, max 60; no saturation is needed.
  - Latency: an audioN edge changes mix after SYNC_STAGES+1 clocks.
  - Changes to vol, volOnly or mute reach mix after 1 clock.
- Sigma-delta: 7-bit accumulator acc.
  - Each clock: acc <= {1'b0, acc[5:0]} + mix, and dacOut <= carry of that addition (bit 6 of the new acc).
  - The density of ones equals mix/64.
  - Over any 64 consecutive clocks with constant mix, the count of ones equals mix exactly.
  - mix=0 gives dacOut=0 from the next clock onward.
- Divider: counter runs 0..SAMPLE_DIV-1 and wraps to 0. strb=1 in the cycle counter==SAMPLE_DIV-1. The first strb comes SAMPLE_DIV clocks after reset release.
- Sample handshake:
  - Transfer occurs when sampleValid && sampleReady.
  - While sampleValid=1 and no transfer, sample is held stable.
  - strb with (sampleValid==0 or transfer this cycle): sample <= mix; sampleValid <= 1; no overrun.
  - strb with sampleValid==1 and no transfer: the new value is dropped, the old sample is kept, overrun <= 1.
  - Transfer without strb: sampleValid <= 0.
  - sampleReady while sampleValid=0 is ignored.
- Overrun:
  - overrunClr clears it on the next clock.
  - A set condition in the same cycle as overrunClr wins (overrun stays 1).
- No combinational path from any input to any output; all outputs are registered.

Test Plan:
1. Reset release, SAMPLE_DIV=40, all volumes 0 -> dacOut, sample, sampleValid, overrun all 0; first sampleValid rises 40 clocks after release with sample=0. Reassert init_L mid-handshake -> sampleValid=0 immediately (asynchronous).
2. volOnly=4'b1111, vol1..4=15 -> mix=60; any 64-clock window of dacOut contains exactly 60 ones; accepted samples read 60.
3. volOnly=0, vol1=8, others 0; audio1 rises at edge t -> mix=8 at edge t+SYNC_STAGES+1 (t+3 by default); audio1 held low -> samples 0, dacOut settles to 0.
4. sampleReady held low across 3 strobes -> sample stays at the first captured value, sampleValid=1, overrun=1 from the second strobe. Assert overrunClr with no strobe -> overrun=0.
5. sampleReady=1 exactly in a strobe cycle with sampleValid=1 -> new sample loaded, sampleValid stays 1, overrun stays 0.
6. mute=1 with all channels at 15 -> mix=0 one clock later, dacOut=0 thereafter, next sample=0; overrunClr coincident with an overrun event -> overrun stays 1.
